icache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the fetch stage and the memory controller.

---
 rtl/icache_if.sv | 23 ++
 rtl/icache.sv | 98 +++++++++
 tb/tb_icache.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// The slave modport is the cache; the master modport is the fetcher and memory controller together.
interface icache_if;
  logic        start_fetch;
  logic [31:0] pc;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  modport slave (
    input  start_fetch, pc, mem_done, mem_data,
    output instr_ready, instr, instr_addr, mem_req, mem_addr
  );

  modport master (
    output start_fetch, pc, mem_done, mem_data,
    input  instr_ready, instr, instr_addr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Hits answer one cycle after accept; misses issue one memory read and answer one cycle after mem_done.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rob_clear,
  icache_if.slave  bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]          state;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [31:0]           pc_aligned;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_pc_bits;

  assign idx            = bus.pc[INDEX_BITS+1:2];
  assign tag            = bus.pc[31:INDEX_BITS+2];
  assign pc_aligned     = {bus.pc[31:2], 2'b00};
  assign unused_pc_bits = ^bus.pc[1:0];

  // mem_addr doubles as the latched miss address; it is held for the whole transaction.
  assign fill_idx = bus.mem_addr[INDEX_BITS+1:2];
  assign fill_tag = bus.mem_addr[31:INDEX_BITS+2];

  assign hit     = valid[idx] && (tag_mem[idx] == tag);
  assign fill_en = rdy && bus.mem_done && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      valid           <= '0;
      bus.instr_ready <= 1'b0;
      bus.instr       <= 32'd0;
      bus.instr_addr  <= 32'd0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= 32'd0;
    end else if (rdy) begin
      bus.instr_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rob_clear && bus.start_fetch && !bus.instr_ready) begin
            if (hit) begin
              bus.instr_ready <= 1'b1;
              bus.instr       <= data_mem[idx];
              bus.instr_addr  <= pc_aligned;
            end else begin
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= pc_aligned;
              state        <= S_MISS;
            end
          end
        end
        S_MISS, S_DROP: begin
          // A flush never aborts the memory read; it only suppresses the response.
          if (bus.mem_done) begin
            valid[fill_idx] <= 1'b1;
            bus.mem_req     <= 1'b0;
            state           <= S_IDLE;
            if (state == S_MISS && !rob_clear) begin
              bus.instr_ready <= 1'b1;
              bus.instr       <= bus.mem_data;
              bus.instr_addr  <= bus.mem_addr;
            end
          end else if (rob_clear) begin
            state <= S_DROP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner sequences,
// then randomized fetches checked against a line-address cache model.
module tb_icache;

  localparam int LINES = 64;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rob_clear;

  icache_if bus ();

  icache #(.INDEX_BITS(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: per line, the full word address it holds and its data.
  bit          mValid [LINES];
  logic [31:0] mLine  [LINES];
  logic [31:0] mData  [LINES];

  typedef struct {
    string       name;
    logic [31:0] pc;
    int          lat;
    int          flushAt;
    logic [31:0] data;
    bit          expHit;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lineOf(input logic [31:0] addr);
    return int'((addr >> 2) % LINES);
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
  endtask

  // Issues one fetch, plays the memory controller on a miss, and checks every cycle of it.
  task automatic applyStimulus(input logic [31:0] addr, input int lat, input int flushAt,
                               input logic [31:0] data, input bit holdStart, input bit stalls,
                               output bit sawHit);
    logic [31:0] aligned;
    int          idx;
    bit          expHit;
    bit          flushed;
    aligned = addr & 32'hFFFF_FFFC;
    idx     = lineOf(addr);
    expHit  = mValid[idx] && (mLine[idx] == aligned);
    flushed = 1'b0;
    bus.start_fetch = 1'b1;
    bus.pc          = addr;
    tick();
    sawHit = bus.instr_ready;
    if (expHit) begin
      checkOutput("hit_pulse", {31'd0, bus.instr_ready}, 32'd1);
      checkOutput("hit_instr", bus.instr, mData[idx]);
      checkOutput("hit_addr", bus.instr_addr, aligned);
      checkOutput("hit_no_memreq", {31'd0, bus.mem_req}, 32'd0);
    end else begin
      checkOutput("miss_req", {31'd0, bus.mem_req}, 32'd1);
      checkOutput("miss_addr", bus.mem_addr, aligned);
      checkOutput("miss_no_pulse", {31'd0, bus.instr_ready}, 32'd0);
      for (int i = 1; i <= lat; i++) begin
        if (stalls && $urandom_range(0, 2) == 0) begin
          rdy = 1'b0;
          tick();
          tick();
          checkOutput("stall_req", {31'd0, bus.mem_req}, 32'd1);
          checkOutput("stall_pulse", {31'd0, bus.instr_ready}, 32'd0);
          rdy = 1'b1;
        end
        if (i == flushAt) begin
          rob_clear       = 1'b1;
          bus.start_fetch = 1'b0;
          flushed         = 1'b1;
        end
        tick();
        rob_clear = 1'b0;
        checkOutput("wait_req", {31'd0, bus.mem_req}, 32'd1);
        checkOutput("wait_addr", bus.mem_addr, aligned);
        checkOutput("wait_pulse", {31'd0, bus.instr_ready}, 32'd0);
      end
      bus.mem_done = 1'b1;
      bus.mem_data = data;
      tick();
      bus.mem_done = 1'b0;
      bus.mem_data = $urandom;
      mValid[idx] = 1'b1;
      mLine[idx]  = aligned;
      mData[idx]  = data;
      checkOutput("fill_req_drop", {31'd0, bus.mem_req}, 32'd0);
      if (flushed) begin
        checkOutput("drop_no_pulse", {31'd0, bus.instr_ready}, 32'd0);
      end else begin
        checkOutput("miss_pulse", {31'd0, bus.instr_ready}, 32'd1);
        checkOutput("miss_instr", bus.instr, data);
        checkOutput("miss_instr_addr", bus.instr_addr, aligned);
      end
    end
    if (!flushed) begin
      if (!holdStart) bus.start_fetch = 1'b0;
      tick();
      checkOutput("single_pulse", {31'd0, bus.instr_ready}, 32'd0);
      checkOutput("no_reaccept", {31'd0, bus.mem_req}, 32'd0);
    end
    bus.start_fetch = 1'b0;
  endtask

  // The memory side of the bench must never complete a read that was not requested.
  always @(negedge clk) begin
    if (bus.mem_done && !bus.mem_req) begin
      testsFailed++;
      $display("[TB] FAIL protocol: mem_done=%b while mem_req=%b", bus.mem_done, bus.mem_req);
    end
  end

  initial begin
    bit          sawHit;
    logic [31:0] addr;
    int          lat;
    int          flushAt;

    vecs[0] = '{"cold_miss",     32'h0000_0000, 5, 0, 32'h0000_0513, 1'b0};
    vecs[1] = '{"hit",           32'h0000_0000, 0, 0, 32'h0,         1'b1};
    vecs[2] = '{"conflict_fill", 32'h0000_0100, 3, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{"conflict_back", 32'h0000_0000, 2, 0, 32'h0000_0513, 1'b0};
    vecs[4] = '{"flush_miss",    32'h0000_0040, 4, 2, 32'h1234_5678, 1'b0};
    vecs[5] = '{"hit_after_drop",32'h0000_0040, 0, 0, 32'h0,         1'b1};
    vecs[6] = '{"low_bits_miss", 32'h0000_0103, 1, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[7] = '{"top_line_miss", 32'h0000_00FC, 2, 0, 32'hCAFE_F00D, 1'b0};
    vecs[8] = '{"top_line_hit",  32'h0000_00FE, 0, 0, 32'h0,         1'b1};

    rst             = 1'b1;
    rdy             = 1'b1;
    rob_clear       = 1'b0;
    bus.start_fetch = 1'b0;
    bus.pc          = 32'd0;
    bus.mem_done    = 1'b0;
    bus.mem_data    = 32'd0;
    clearModel();
    #12;
    checkOutput("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
    checkOutput("rst_instr", bus.instr, 32'd0);
    checkOutput("rst_instr_addr", bus.instr_addr, 32'd0);
    checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].pc, vecs[v].lat, vecs[v].flushAt, vecs[v].data, 1'b0, 1'b0, sawHit);
      checkOutput({vecs[v].name, "_class"}, {31'd0, sawHit}, {31'd0, vecs[v].expHit});
    end

    // Stall on a hit-accept edge, then across the response pulse.
    bus.start_fetch = 1'b1;
    bus.pc          = 32'h0000_0040;
    rdy             = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_accept_pulse", {31'd0, bus.instr_ready}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    checkOutput("stall_hit_pulse", {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("stall_hit_instr", bus.instr, 32'h1234_5678);
    bus.start_fetch = 1'b0;
    rdy             = 1'b0;
    tick();
    checkOutput("stall_pulse_frozen", {31'd0, bus.instr_ready}, 32'd1);
    rdy = 1'b1;
    tick();
    checkOutput("stall_pulse_end", {31'd0, bus.instr_ready}, 32'd0);

    // Three-cycle stall in the middle of a miss.
    bus.start_fetch = 1'b1;
    bus.pc          = 32'h0000_0240;
    tick();
    checkOutput("stall_miss_req", {31'd0, bus.mem_req}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_miss_hold", {31'd0, bus.mem_req}, 32'd1);
      checkOutput("stall_miss_addr", bus.mem_addr, 32'h0000_0240);
      checkOutput("stall_miss_pulse", {31'd0, bus.instr_ready}, 32'd0);
    end
    rdy          = 1'b1;
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h0BAD_F00D;
    tick();
    bus.mem_done    = 1'b0;
    bus.start_fetch = 1'b0;
    checkOutput("stall_miss_resume", {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("stall_miss_instr", bus.instr, 32'h0BAD_F00D);
    mValid[lineOf(32'h240)] = 1'b1;
    mLine[lineOf(32'h240)]  = 32'h0000_0240;
    mData[lineOf(32'h240)]  = 32'h0BAD_F00D;
    tick();

    // Back-to-back: start_fetch held straight through the pulse.
    applyStimulus(32'h0000_0240, 0, 0, 32'h0, 1'b1, 1'b0, sawHit);
    applyStimulus(32'h0000_0240, 0, 0, 32'h0, 1'b0, 1'b0, sawHit);

    // Asynchronous reset in the middle of a miss.
    bus.start_fetch = 1'b1;
    bus.pc          = 32'h0000_0300;
    tick();
    checkOutput("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("async_rst_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst             = 1'b0;
    bus.start_fetch = 1'b0;
    clearModel();
    applyStimulus(32'h0000_0300, 2, 0, memWord(32'h300), 1'b0, 1'b0, sawHit);
    checkOutput("post_rst_miss", {31'd0, sawHit}, 32'd0);
    applyStimulus(32'h0000_0040, 1, 0, memWord(32'h40), 1'b0, 1'b0, sawHit);
    checkOutput("post_rst_valid_cleared", {31'd0, sawHit}, 32'd0);

    // Randomized traffic over a small address pool so hits, conflicts and flushes all recur.
    for (int n = 0; n < 120; n++) begin
      addr    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
      lat     = $urandom_range(0, 4);
      flushAt = (lat > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
      applyStimulus(addr, lat, flushAt, memWord(addr & 32'hFFFF_FFFC),
                    1'($urandom_range(0, 1)), 1'b1, sawHit);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
